// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of the data-memory port, CPU vs DMA/loader.
// Define ARB_PERF_EN to add stall/grant counters with a perf_clr input.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [1:0]        cpu_wmode,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_lock,
  input  logic [1:0]        dma_wmode,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic [31:0]       dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_w,
  input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [15:0]       cpu_wait_cnt,
  output logic [15:0]       dma_grant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    G_CPU = 2'd1,
    G_DMA = 2'd2
  } gnt_e;

  localparam logic [3:0] MAX_L = 4'(MAX_LOCK);

  gnt_e       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;

  logic unused_addr_hi;
  assign unused_addr_hi = ^{cpu_addr[31:ADDR_W],
                            dma_addr[31:ADDR_W]};

  // Arbitration: next owner, burst counter, last-owner tracking.
  always_comb begin
    gnt_d      = IDLE;
    last_d     = last_q;
    lock_cnt_d = '0;
    unique case (1'b1)
      cpu_req && dma_req: begin
        if (gnt_q == G_DMA && dma_lock &&
            lock_cnt_q < MAX_L)
          gnt_d = G_DMA;
        else if (last_q)
          gnt_d = G_CPU;
        else
          gnt_d = G_DMA;
      end
      cpu_req && !dma_req: gnt_d = G_CPU;
      !cpu_req && dma_req: gnt_d = G_DMA;
      default: ;
    endcase
    if (gnt_d == G_CPU) last_d = 1'b0;
    if (gnt_d == G_DMA) last_d = 1'b1;
    if (gnt_q == G_DMA && gnt_d == G_DMA && cpu_req)
      lock_cnt_d = (lock_cnt_q >= MAX_L) ? MAX_L
                 : lock_cnt_q + 4'd1;
  end

  // Grant state register; last resets to DMA so CPU wins first tie.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      gnt_q      <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Port steering; a dropped request in its grant cycle writes nothing.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_w     = 2'b00;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    cpu_rdata = '0;
    dma_rdata = '0;
    unique case (gnt_q)
      G_CPU: begin
        mem_addr  = cpu_addr[ADDR_W-1:0];
        mem_wdata = cpu_wdata;
        mem_w     = cpu_req ? cpu_wmode : 2'b00;
        cpu_ack   = cpu_req;
        cpu_rdata = mem_rdata;
      end
      G_DMA: begin
        mem_addr  = dma_addr[ADDR_W-1:0];
        mem_wdata = dma_wdata;
        mem_w     = dma_req ? dma_wmode : 2'b00;
        dma_ack   = dma_req;
        dma_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req & (gnt_q != G_CPU);

`ifdef ARB_PERF_EN
  logic [15:0] wait_q, wait_d;
  logic [15:0] dgnt_q, dgnt_d;

  // Saturating counters, synchronously cleared by perf_clr.
  always_comb begin
    wait_d = wait_q;
    dgnt_d = dgnt_q;
    if (perf_clr) begin
      wait_d = '0;
      dgnt_d = '0;
    end else begin
      if (cpu_stall && wait_q != 16'hFFFF)
        wait_d = wait_q + 16'd1;
      if (dma_ack && dgnt_q != 16'hFFFF)
        dgnt_d = dgnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      dgnt_q <= '0;
    end else begin
      wait_q <= wait_d;
      dgnt_q <= dgnt_d;
    end
  end

  assign cpu_wait_cnt  = wait_q;
  assign dma_grant_cnt = dgnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench, reference model vs dmem_arbiter.
// Per-cycle expectations are queued by stimulus and popped by a monitor.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int ML = 4;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          reset = 1'b0;
  logic          cpu_req = 1'b0;
  logic [1:0]    cpu_wmode = '0;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;
  logic          dma_req = 1'b0;
  logic          dma_lock = 1'b0;
  logic [1:0]    dma_wmode = '0;
  logic [31:0]   dma_addr = '0;
  logic [31:0]   dma_wdata = '0;
  logic [31:0]   dma_rdata;
  logic          dma_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [1:0]    mem_w;
  logic [31:0]   mem_rdata;
`ifdef ARB_PERF_EN
  logic          perf_clr = 1'b0;
  logic [15:0]   cpu_wait_cnt;
  logic [15:0]   dma_grant_cnt;
`endif

  dmem_arbiter #(.ADDR_W(AW), .MAX_LOCK(ML)) dut (
    .clk_in(clk_in), .reset(reset),
    .cpu_req(cpu_req), .cpu_wmode(cpu_wmode),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_lock(dma_lock),
    .dma_wmode(dma_wmode), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
    .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_w(mem_w), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
    ,
    .perf_clr(perf_clr),
    .cpu_wait_cnt(cpu_wait_cnt),
    .dma_grant_cnt(dma_grant_cnt)
`endif
  );

  // Byte-lane data memory attached to the arbiter.
  bit [7:0] tmem [256];
  assign mem_rdata = {tmem[{mem_addr[7:2], 2'b11}],
                      tmem[{mem_addr[7:2], 2'b10}],
                      tmem[{mem_addr[7:2], 2'b01}],
                      tmem[{mem_addr[7:2], 2'b00}]};
  always @(posedge clk_in) begin
    case (mem_w)
      2'b01: tmem[mem_addr] <= mem_wdata[7:0];
      2'b10: begin
        tmem[{mem_addr[7:1], 1'b0}] <= mem_wdata[7:0];
        tmem[{mem_addr[7:1], 1'b1}] <= mem_wdata[15:8];
      end
      2'b11: begin
        tmem[{mem_addr[7:2], 2'b00}] <= mem_wdata[7:0];
        tmem[{mem_addr[7:2], 2'b01}] <= mem_wdata[15:8];
        tmem[{mem_addr[7:2], 2'b10}] <= mem_wdata[23:16];
        tmem[{mem_addr[7:2], 2'b11}] <= mem_wdata[31:24];
      end
      default: ;
    endcase
  end

  typedef struct {
    logic        ca, da, st;
    logic [1:0]  mw;
    logic [7:0]  ma;
    logic [31:0] mwd, crd, drd;
    int          wc, gc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   done = 1'b0;

  // Reference model: owner 0 none, 1 cpu, 2 dma.
  bit [7:0]    sh [256];
  int          m_own = 0, m_last = 2, m_streak = 0;
  int          m_wait = 0, m_grant = 0;
  bit          pw = 0, p_st = 0, p_da = 0;
  bit          l_ca = 0, l_da = 0;
  logic [1:0]  pwm;
  logic [7:0]  pa;
  logic [31:0] pwd;

  function automatic logic [31:0] sh_rd(logic [7:0] a);
    int b;
    b = int'(a) & 252;
    return {sh[b+3], sh[b+2], sh[b+1], sh[b]};
  endfunction

  task automatic sh_wr(logic [7:0] a, logic [1:0] m,
                       logic [31:0] d);
    int b;
    int n;
    n = (m == 2'd1) ? 1 : (m == 2'd2) ? 2 : 4;
    b = int'(a) & ~(n - 1);
    for (int i = 0; i < n; i++) sh[b+i] = d[8*i +: 8];
  endtask

  task automatic model_reset();
    m_own = 0; m_last = 2; m_streak = 0;
    m_wait = 0; m_grant = 0; pw = 0;
  endtask

  // Clock edge: commit last cycle's write, choose next owner.
  task automatic begin_cycle();
    int nxt;
    @(posedge clk_in);
    #1;
    if (!reset) model_reset();
    else begin
      if (pw) sh_wr(pa, pwm, pwd);
      if (cpu_req && dma_req) begin
        if (m_own == 2 && dma_lock && m_streak < ML) nxt = 2;
        else nxt = (m_last == 1) ? 2 : 1;
      end else if (cpu_req) nxt = 1;
      else if (dma_req) nxt = 2;
      else nxt = 0;
      if (m_own == 2 && nxt == 2 && cpu_req)
        m_streak = (m_streak < ML) ? m_streak + 1 : ML;
      else
        m_streak = 0;
      if (nxt != 0) m_last = nxt;
      m_own = nxt;
`ifdef ARB_PERF_EN
      if (perf_clr) begin
        m_wait = 0; m_grant = 0;
      end else begin
        if (p_st && m_wait < 65535) m_wait++;
        if (p_da && m_grant < 65535) m_grant++;
      end
`endif
    end
    pw = 0;
  endtask

  // Expected outputs for the cycle just driven.
  task automatic predict();
    exp_t e;
    e = '{default: 0};
    if (!reset) model_reset();
    e.st = cpu_req && (m_own != 1);
    if (m_own == 1) begin
      e.ma = cpu_addr[7:0]; e.mwd = cpu_wdata;
      e.ca = cpu_req; e.mw = cpu_req ? cpu_wmode : 2'b00;
      e.crd = sh_rd(cpu_addr[7:0]);
    end else if (m_own == 2) begin
      e.ma = dma_addr[7:0]; e.mwd = dma_wdata;
      e.da = dma_req; e.mw = dma_req ? dma_wmode : 2'b00;
      e.drd = sh_rd(dma_addr[7:0]);
    end
    if (e.mw != 2'b00) begin
      pw = 1; pwm = e.mw; pa = e.ma; pwd = e.mwd;
    end
    e.wc = m_wait; e.gc = m_grant;
    l_ca = e.ca; l_da = e.da; p_st = e.st; p_da = e.da;
    q.push_back(e);
  endtask

  task automatic step(input bit rst, input bit cr,
                      input logic [1:0] cw,
                      input logic [31:0] ca, input logic [31:0] cd,
                      input bit dr, input bit dl,
                      input logic [1:0] dw,
                      input logic [31:0] da, input logic [31:0] dd);
    begin_cycle();
    reset = rst; cpu_req = cr; cpu_wmode = cw;
    cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_lock = dl; dma_wmode = dw;
    dma_addr = da; dma_wdata = dd;
`ifdef ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    predict();
  endtask

  function automatic void chk(string nm, logic [31:0] got,
                              logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, got, want, $time);
    end
  endfunction

  // Monitor: pops one expectation per cycle and compares.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (done) break;
      if (q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL scoreboard: no expectation at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("cpu_ack", 32'(cpu_ack), 32'(e.ca));
        chk("dma_ack", 32'(dma_ack), 32'(e.da));
        chk("cpu_stall", 32'(cpu_stall), 32'(e.st));
        chk("mem_w", 32'(mem_w), 32'(e.mw));
        chk("mem_addr", 32'(mem_addr), 32'(e.ma));
        chk("mem_wdata", mem_wdata, e.mwd);
        chk("cpu_rdata", cpu_rdata, e.crd);
        chk("dma_rdata", dma_rdata, e.drd);
`ifdef ARB_PERF_EN
        chk("cpu_wait_cnt", 32'(cpu_wait_cnt), 32'(e.wc));
        chk("dma_grant_cnt", 32'(dma_grant_cnt), 32'(e.gc));
`endif
      end
    end
    chk("leftover", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin : stim
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 32'hABCD0010, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(1, 1, 3, 32'hABCD0010, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h00000010, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, 32'(i * 4), 0, 1, 0, 0, 32'(64 + i * 4), 0);
    for (int i = 0; i < 12; i++)
      step(1, 1, 1, 32'(8'h40 + i), 32'(i),
           1, 1, 3, 32'(8'h80 + 4 * (i % 4)), $urandom());
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 3, 32'h20, 32'h12345678);
    step(1, 0, 0, 0, 0, 0, 0, 3, 32'h20, 32'h12345678);
    step(1, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 32'h30, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    step(0, 1, 3, 32'h30, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h30, 0, 1, 0, 0, 32'h34, 0);
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 32'h30, 0, 1, 0, 0, 32'h34, 0);
    for (int n = 0; n < 1500; n++) begin
      begin_cycle();
      if (cpu_req && !l_ca) begin
        if (m_own == 1 && $urandom_range(0, 15) == 0)
          cpu_req = 1'b0;
      end else begin
        cpu_req   = ($urandom_range(0, 9) < 6);
        cpu_wmode = 2'($urandom_range(0, 3));
        cpu_addr  = ($urandom() & 32'hFFFFFF00) |
                    32'($urandom_range(0, 63));
        cpu_wdata = $urandom();
      end
      if (dma_req && !l_da) begin
        if (m_own == 2 && $urandom_range(0, 15) == 0)
          dma_req = 1'b0;
      end else begin
        dma_req   = ($urandom_range(0, 9) < 6);
        dma_wmode = 2'($urandom_range(0, 3));
        dma_addr  = ($urandom() & 32'hFFFFFF00) |
                    32'($urandom_range(0, 63));
        dma_wdata = $urandom();
      end
      dma_lock = ($urandom_range(0, 9) < 5);
`ifdef ARB_PERF_EN
      perf_clr = ($urandom_range(0, 49) == 0);
`endif
      predict();
    end
    @(negedge clk_in);
    #1;
    done = 1'b1;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (byte address, 2-bit write-mode, synchronous write, combinational read) between two requesters: the CPU load/store path and a DMA/debug loader.
- Sits between the cpu core, the loader, and the data memory in the top-level dataflow.
- Round-robin arbitration with an optional DMA burst lock.
- Holds the CPU with a stall while the DMA owns the port.

Parameters:
- ADDR_W, 8, number of memory address bits driven to the data memory.
- MAX_LOCK, 4, maximum consecutive DMA grants under dma_lock while cpu_req is pending (range 1..15).

Ports:
- clk_in  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_wmode  in  2  00 read, 01 byte write, 10 half write, 11 word write
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  read data to CPU
- cpu_ack  out  1  CPU access performed this cycle
- cpu_stall  out  1  CPU must hold PC/state this cycle
- dma_req  in  1  DMA access request; held until dma_ack
- dma_lock  in  1  DMA requests consecutive grants (burst)
- dma_wmode  in  2  same encoding as cpu_wmode
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_rdata  out  32  read data to DMA
- dma_ack  out  1  DMA access performed this cycle
- mem_addr  out  ADDR_W  to data memory address
- mem_wdata  out  32  to data memory write data
- mem_w  out  2  to data memory write mode
- mem_rdata  in  32  from data memory read data

Behaviour:
- State register gnt: IDLE, G_CPU, G_DMA. Register last (owner of last grant, reset = DMA so CPU wins the first tie). Register lock_cnt, 4 bits.
- reset low, asynchronous: gnt=IDLE, last=DMA, lock_cnt=0.
  - Outputs while in reset: all acks 0, cpu_stall=cpu_req, mem_w=00, mem_addr=0, mem_wdata=0, rdata=0.
- Next-state arbitration at each rising edge, using the current-cycle requests:
  - Neither request -> IDLE.
  - Only one request -> that requester.
  - Both requesting:
    - DMA wins if gnt==G_DMA, dma_lock=1 and lock_cnt<MAX_LOCK.
    - Otherwise the requester that is not last wins.
- A requester that is granted now and keeps req high counts as a new request. Back-to-back single-requester accesses therefore run at 1 per cycle.
- lock_cnt:
  - Increments on each G_DMA->G_DMA transition while cpu_req=1.
  - Clears on any other transition.
  - Saturates at MAX_LOCK.
- last is updated to the owner whenever gnt enters G_CPU or G_DMA.
- Datapath in state G_x, combinational:
  - mem_addr = x_addr[ADDR_W-1:0], mem_wdata = x_wdata.
  - mem_w = x_req ? x_wmode : 00.
  - x_ack = x_req.
  - x_rdata = mem_rdata.
  - The other requester's rdata = 0.
- In IDLE: mem_w=00, acks 0, mem_addr=0.
- cpu_stall = cpu_req & ~(gnt==G_CPU). Latency: a request raised in cycle n is acked no earlier than cycle n+1.
- Aborted access: if the granted requester drops req during its grant cycle, there is no write (mem_w=00) and no ack. The state still advances normally at the next edge.
- Writes commit at the clock edge ending the ack cycle. Reads are valid combinationally during the ack cycle.
- Address bits above ADDR_W-1 are ignored. There is no alignment checking; the memory handles byte/half lanes.
- Reset asserted mid-access: the in-flight write is not committed because mem_w is forced to 00 immediately.

Optional Feature:
- Macro: ARB_PERF_EN.
- When defined, two extra outputs are added:
  - cpu_wait_cnt  out  16: counts cycles with cpu_stall=1.
  - dma_grant_cnt  out  16: counts dma_ack cycles.
- Both counters are saturating, reset to 0 asynchronously, and cleared synchronously by an extra input perf_clr.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- CPU only: cpu_req=1, word write 0xDEADBEEF to addr 0x10, then read 0x10 -> write ack in cycle 1, read ack next cycle with cpu_rdata=0xDEADBEEF; cpu_stall=0 on both ack cycles.
- Simultaneous cpu_req=dma_req=1 from reset, no lock -> grants alternate CPU, DMA, CPU, DMA; cpu_stall=1 exactly on DMA cycles.
- DMA burst: dma_lock=1, MAX_LOCK=4, CPU also requesting -> 5 consecutive DMA acks (entry plus 4 locked), then a CPU grant; the CPU stalls 5 cycles.
- Abort: DMA granted, dma_req dropped in its grant cycle with wmode=11 -> mem_w=00, dma_ack=0, memory contents unchanged.
- Async reset low mid-write (CPU grant, wmode=11) -> mem_w=00 immediately, gnt=IDLE, no write to memory; after release the CPU wins the first tie.
- ARB_PERF_EN: 10 cycles of CPU stall -> cpu_wait_cnt=10; perf_clr pulse -> 0; counter holds at 0xFFFF when saturated.
